id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and three-source operand forwarding.
// The register captures decode fields each cycle. The operands are then resolved
// combinationally from the registered fields and the EX/MEM and MEM/WB write ports.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  // decode side
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wa,
  input  logic [4:0]  id_alu_ctl,
  input  logic        id_sign,
  input  logic        id_src1_sh,
  input  logic        id_src2_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_dual_write,
  // hazard and forwarding
  input  logic        flush,
  input  logic        stall_ext,
  input  logic        em_reg_write,
  input  logic [4:0]  em_wa,
  input  logic [31:0] em_result,
  input  logic        em_reg_write2,
  input  logic [4:0]  em_wa2,
  input  logic [31:0] em_result2,
  input  logic        mw_reg_write,
  input  logic [4:0]  mw_wa,
  input  logic [31:0] mw_data,
  // EX side
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_ctl,
  output logic        alu_sign,
  output logic        ex_valid,
  output logic [4:0]  ex_wa,
  output logic [4:0]  ex_wa2,
  output logic [31:0] ex_rt_fwd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_dual_write,
  output logic        stall_id
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [4:0]  alu_ctl;
    logic        sign;
    logic        src1_sh;
    logic        src2_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        dual_write;
  } idex_t;

  idex_t idex_reg;
  idex_t idex_next;
  idex_t id_fields;
  logic  load_use;

  // Gather the decode fields into one record so that load/bubble/hold is a single mux.
  always_comb begin
    id_fields            = '0;
    id_fields.valid      = id_valid;
    id_fields.rs_data    = id_rs_data;
    id_fields.rt_data    = id_rt_data;
    id_fields.imm        = id_imm;
    id_fields.shamt      = id_shamt;
    id_fields.rs         = id_rs;
    id_fields.rt         = id_rt;
    id_fields.wa         = id_wa;
    id_fields.alu_ctl    = id_alu_ctl;
    id_fields.sign       = id_sign;
    id_fields.src1_sh    = id_src1_sh;
    id_fields.src2_imm   = id_src2_imm;
    id_fields.reg_write  = id_reg_write;
    id_fields.mem_read   = id_mem_read;
    id_fields.mem_write  = id_mem_write;
    id_fields.mem_to_reg = id_mem_to_reg;
    id_fields.dual_write = id_dual_write;
  end

  // A load in EX whose target is read by the instruction in ID needs one bubble.
  // Writes to $0 are discarded, so a load targeting $0 never creates a hazard.
  assign load_use = idex_reg.valid & idex_reg.mem_read & id_valid &
                    (idex_reg.wa != 5'd0) &
                    ((idex_reg.wa == id_rs) | (idex_reg.wa == id_rt));

  // A flush squashes the dependent instruction anyway, so it cancels the load-use hold.
  assign stall_id = (load_use & ~flush) | stall_ext;

  // Next-state selection. A downstream freeze takes priority over a flush, which
  // means the issuer has to re-assert the flush once the freeze is released.
  always_comb begin
    idex_next = idex_reg;
    if (stall_ext)
      idex_next = idex_reg;
    else if (flush || load_use)
      idex_next = '0;
    else
      idex_next = id_fields;
  end

  // ID/EX register; reset always leaves a bubble, even during a freeze.
  always_ff @(posedge clk) begin
    if (reset)
      idex_reg <= '0;
    else
      idex_reg <= idex_next;
  end

  // Operand forwarding. Index 0 resolves rs and index 1 resolves rt.
  // The youngest producer wins: EX/MEM primary, then EX/MEM secondary, then MEM/WB.
  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] src_data;
  logic [1:0][31:0] fwd;
  logic [1:0]       hit_em;
  logic [1:0]       hit_em2;
  logic [1:0]       hit_mw;

  assign src_addr[0] = idex_reg.rs;
  assign src_addr[1] = idex_reg.rt;
  assign src_data[0] = idex_reg.rs_data;
  assign src_data[1] = idex_reg.rt_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign hit_em[gi]  = em_reg_write  & (em_wa  != 5'd0) & (em_wa  == src_addr[gi]);
    assign hit_em2[gi] = em_reg_write2 & (em_wa2 != 5'd0) & (em_wa2 == src_addr[gi]);
    assign hit_mw[gi]  = mw_reg_write  & (mw_wa  != 5'd0) & (mw_wa  == src_addr[gi]);
    assign fwd[gi]     = hit_em[gi]  ? em_result  :
                         hit_em2[gi] ? em_result2 :
                         hit_mw[gi]  ? mw_data    : src_data[gi];
  end

  assign alu_in1       = idex_reg.src1_sh  ? {27'b0, idex_reg.shamt} : fwd[0];
  assign alu_in2       = idex_reg.src2_imm ? idex_reg.imm            : fwd[1];
  assign ex_rt_fwd     = fwd[1];
  assign alu_ctl       = idex_reg.alu_ctl;
  assign alu_sign      = idex_reg.sign;
  assign ex_valid      = idex_reg.valid;
  assign ex_wa         = idex_reg.wa;
  assign ex_wa2        = idex_reg.rs;
  assign ex_reg_write  = idex_reg.reg_write;
  assign ex_mem_read   = idex_reg.mem_read;
  assign ex_mem_write  = idex_reg.mem_write;
  assign ex_mem_to_reg = idex_reg.mem_to_reg;
  assign ex_dual_write = idex_reg.dual_write;

endmodule
